// File: rtl/vadd_stream_feeder_if.sv
// Bundle of the feeder's serial input stream, vadd vector bus and serial output stream.
interface vadd_stream_feeder_if #(
  parameter int W     = 8,
  parameter int LANES = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       in_a;
  logic [W-1:0]       in_b;
  logic               in_last;
  logic [W*LANES-1:0] vec_a;
  logic [W*LANES-1:0] vec_b;
  logic               en;
  logic [W*LANES-1:0] vec_y;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_data;
  logic               out_last;

  modport slave (
    input  in_valid, in_a, in_b, in_last, vec_y, out_ready,
    output in_ready, vec_a, vec_b, en, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_a, in_b, in_last, vec_y, out_ready,
    input  in_ready, vec_a, vec_b, en, out_valid, out_data, out_last
  );
endinterface

// File: rtl/vadd_stream_feeder.sv
// Packs (a,b) pairs into LANES-wide vectors for vadd, skews a behind b, and
// re-serialises vadd results with back-pressure that freezes the adder pipeline.
module vadd_stream_feeder #(
  parameter int W      = 8,
  parameter int LANES  = 4,
  parameter int LAT    = 3,
  parameter int A_SKEW = 1
) (
  input logic                 clock,
  input logic                 reset,
  vadd_stream_feeder_if.slave bus
);
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int NW = $clog2(LANES + 1);

  logic [W-1:0]       pack_a [LANES];
  logic [W-1:0]       pack_b [LANES];
  logic [W*LANES-1:0] pack_a_flat;
  logic [W*LANES-1:0] pack_b_flat;
  logic [CW-1:0]      count;
  logic               full;
  logic               pk_last;
  logic [NW-1:0]      pk_nl;

  logic [W*LANES-1:0] hold_b;
  logic [W*LANES-1:0] skew_a [A_SKEW];

  logic               tag_vld  [LAT];
  logic               tag_last [LAT];
  logic [NW-1:0]      tag_nl   [LAT];

  logic [W-1:0]       buf_lane [LANES];
  logic               buf_vld;
  logic               buf_last;
  logic [NW-1:0]      buf_nl;
  logic [NW-1:0]      idx;

  logic en, stall, busy, issue, accept, complete, count_top;
  logic capture, drain_fire, drain_final, at_tail;

  always_comb begin
    pack_a_flat = '0;
    pack_b_flat = '0;
    for (int i = 0; i < LANES; i++) begin
      pack_a_flat[i*W +: W] = pack_a[i];
      pack_b_flat[i*W +: W] = pack_b[i];
    end
  end

  // Buffer frees on its final handshake, so a waiting result may load without a bubble
  assign at_tail     = (idx == buf_nl - NW'(1));
  assign drain_fire  = bus.out_valid & bus.out_ready;
  assign drain_final = drain_fire & at_tail;
  assign busy        = buf_vld & ~drain_final;
  assign stall       = tag_vld[LAT-1] & busy;
  assign en          = ~reset & ~stall;
  assign capture     = tag_vld[LAT-1] & en;

  assign issue       = full & en;
  assign count_top   = (count == CW'(LANES - 1));
  assign accept      = bus.in_valid & bus.in_ready;
  assign complete    = accept & (bus.in_last | count_top);

  assign bus.in_ready  = ~reset & ~(full & ~en);
  assign bus.en        = en;
  assign bus.vec_b     = issue ? pack_b_flat : hold_b;
  assign bus.vec_a     = skew_a[A_SKEW-1];
  assign bus.out_valid = buf_vld & ~reset;
  assign bus.out_last  = bus.out_valid & buf_last & at_tail;
  assign bus.out_data  = bus.out_valid ? buf_lane[idx[CW-1:0]] : '0;

  // Stage p0: packer; lane 0 write clears the other lanes so partial vectors are zero-filled
  always_ff @(posedge clock) begin
    if (reset) begin
      full  <= 1'b0;
      count <= '0;
    end else begin
      full <= (full & ~issue) | complete;
      if (accept) count <= complete ? '0 : count + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (CW'(i) == count) begin
          pack_a[i] <= bus.in_a;
          pack_b[i] <= bus.in_b;
        end else if (count == '0) begin
          pack_a[i] <= '0;
          pack_b[i] <= '0;
        end
      end
    end
    if (complete) begin
      pk_last <= bus.in_last;
      pk_nl   <= NW'(count) + NW'(1);
    end
  end

  // Stage p1: issue; b goes straight out, a trails by A_SKEW enabled cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_b <= '0;
      for (int k = 0; k < A_SKEW; k++) skew_a[k] <= '0;
    end else begin
      if (issue) hold_b <= pack_b_flat;
      if (issue) skew_a[0] <= pack_a_flat;
      if (en) begin
        for (int k = 1; k < A_SKEW; k++) skew_a[k] <= skew_a[k-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < LAT; k++) tag_vld[k] <= 1'b0;
    end else if (en) begin
      tag_vld[0] <= issue;
      for (int k = 1; k < LAT; k++) tag_vld[k] <= tag_vld[k-1];
    end
  end

  always_ff @(posedge clock) begin
    if (en) begin
      tag_last[0] <= pk_last;
      tag_nl[0]   <= pk_nl;
      for (int k = 1; k < LAT; k++) begin
        tag_last[k] <= tag_last[k-1];
        tag_nl[k]   <= tag_nl[k-1];
      end
    end
  end

  // Stage p2: result buffer, drained one lane per handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_vld <= 1'b0;
      idx     <= '0;
    end else if (capture) begin
      buf_vld <= 1'b1;
      idx     <= '0;
    end else if (drain_final) begin
      buf_vld <= 1'b0;
    end else if (drain_fire) begin
      idx <= idx + NW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (capture) begin
      for (int i = 0; i < LANES; i++) buf_lane[i] <= bus.vec_y[i*W +: W];
      buf_last <= tag_last[LAT-1];
      buf_nl   <= tag_nl[LAT-1];
    end
  end
endmodule

// File: tb/tb_vadd_stream_feeder.sv
// Bench for vadd_stream_feeder with a behavioural vadd (B: 2 regs, C: 1 reg, P reg).
module tb_vadd_stream_feeder;
  localparam int W = 8;
  localparam int LANES = 4;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   out_count = 0;
  int   last_acc_cyc = 0;
  int   first_out_cyc = 0;
  bit   lat_armed = 0;
  exp_t q[$];

  vadd_stream_feeder_if #(.W(W), .LANES(LANES)) bus ();

  vadd_stream_feeder #(.W(W), .LANES(LANES), .LAT(3), .A_SKEW(1)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Behavioural vadd: b through two registers, a through one, sum into P
  logic [7:0] b1 [LANES];
  logic [7:0] b2 [LANES];
  logic [7:0] c1 [LANES];
  logic [7:0] p  [LANES];

  always @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (reset) begin
        b1[i] <= '0; b2[i] <= '0; c1[i] <= '0; p[i] <= '0;
      end else if (bus.en) begin
        b1[i] <= bus.vec_b[i*8 +: 8];
        b2[i] <= b1[i];
        c1[i] <= bus.vec_a[i*8 +: 8];
        p[i]  <= b2[i] + c1[i];
      end
    end
  end

  always_comb begin
    bus.vec_y = '0;
    for (int i = 0; i < LANES; i++) bus.vec_y[i*8 +: 8] = p[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Monitor: pops the scoreboard on each output handshake
  initial forever begin
    exp_t e;
    @(negedge clock);
    if (lat_armed && bus.out_valid) begin
      first_out_cyc = cyc;
      lat_armed = 0;
    end
    if (!reset && bus.out_valid && bus.out_ready) begin
      out_count++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0d required=no_output", bus.out_data);
      end else begin
        e = q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e.d));
        chk("out_last", 32'(bus.out_last), 32'(e.l));
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last,
                      input logic [7:0] expd);
    int   n;
    bit   acc;
    exp_t e;
    n = 0;
    acc = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_last = last;
    while (!acc && n < 1000) begin
      @(negedge clock);
      if (bus.in_ready) begin
        acc = 1;
        e.d = expd;
        e.l = last;
        q.push_back(e);
        last_acc_cyc = cyc;
      end
      @(posedge clock);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic drain(input string name, input int base, input int expect_n);
    int n;
    n = 0;
    while ((q.size() != 0 || bus.out_valid) && n < 4000) begin
      @(negedge clock);
      n++;
    end
    repeat (6) @(negedge clock);
    chk({name, "_queue_empty"}, 32'(q.size()), 32'd0);
    chk({name, "_out_count"}, 32'(out_count - base), 32'(expect_n));
    @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int  base;
    bit  saw_en_low, saw_rdy_low, seen, done;
    logic [7:0] ra, rb, rs;
    logic       rl;

    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_en", 32'(bus.en), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_vec_a", bus.vec_a, 32'd0);
    chk("rst_vec_b", bus.vec_b, 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Single vector and latency
    base = out_count;
    lat_armed = 1;
    send(8'd10, 8'd20, 1'b0, 8'd30);
    send(8'd1, 8'd2, 1'b0, 8'd3);
    send(8'd100, 8'd27, 1'b0, 8'd127);
    send(8'd0, 8'd0, 1'b0, 8'd0);
    drain("t1", base, 4);
    chk("t1_latency", 32'(first_out_cyc - (last_acc_cyc + 1)), 32'd4);

    // Wrap-around with a short last vector
    base = out_count;
    send(8'd200, 8'd100, 1'b0, 8'd44);
    send(8'd255, 8'd1, 1'b1, 8'd0);
    drain("t2", base, 2);

    // Back-pressure
    base = out_count;
    saw_en_low = 0;
    saw_rdy_low = 0;
    fork
      begin
        bus.out_ready = 1'b0;
        repeat (20) begin
          @(posedge clock);
          #1;
          if (!bus.en) saw_en_low = 1;
          if (!bus.in_ready) saw_rdy_low = 1;
        end
        bus.out_ready = 1'b1;
      end
      begin
        send(8'd1, 8'd1, 1'b0, 8'd2);
        send(8'd2, 8'd2, 1'b0, 8'd4);
        send(8'd3, 8'd3, 1'b0, 8'd6);
        send(8'd4, 8'd4, 1'b0, 8'd8);
        send(8'd50, 8'd60, 1'b0, 8'd110);
        send(8'd70, 8'd80, 1'b0, 8'd150);
        send(8'd90, 8'd100, 1'b0, 8'd190);
        send(8'd110, 8'd120, 1'b0, 8'd230);
        send(8'd128, 8'd128, 1'b0, 8'd0);
        send(8'd129, 8'd130, 1'b0, 8'd3);
        send(8'd250, 8'd10, 1'b0, 8'd4);
        send(8'd17, 8'd18, 1'b0, 8'd35);
      end
    join
    chk("t3_en_dropped", 32'(saw_en_low), 32'd1);
    chk("t3_in_ready_dropped", 32'(saw_rdy_low), 32'd1);
    drain("t3", base, 12);

    // Skew: vec_a must show the a lanes exactly one cycle after vec_b issues
    base = out_count;
    seen = 0;
    fork
      begin
        int n;
        n = 0;
        while (!seen && n < 200) begin
          @(negedge clock);
          n++;
          if (bus.en && bus.vec_b == 32'h04030201) begin
            seen = 1;
            chk("t4_vec_a_at_issue", bus.vec_a, 32'h11FA8180);
            @(negedge clock);
            chk("t4_vec_a_after_skew", bus.vec_a, 32'h05050505);
          end
        end
        chk("t4_issue_seen", 32'(seen), 32'd1);
      end
      begin
        send(8'd5, 8'd1, 1'b0, 8'd6);
        send(8'd5, 8'd2, 1'b0, 8'd7);
        send(8'd5, 8'd3, 1'b0, 8'd8);
        send(8'd5, 8'd4, 1'b0, 8'd9);
      end
    join
    drain("t4", base, 4);

    // Reset mid-burst: one vector in flight plus a partial one are dropped
    send(8'd1, 8'd1, 1'b0, 8'd2);
    send(8'd2, 8'd3, 1'b0, 8'd5);
    send(8'd4, 8'd5, 1'b0, 8'd9);
    send(8'd6, 8'd7, 1'b0, 8'd13);
    send(8'd8, 8'd9, 1'b0, 8'd17);
    send(8'd10, 8'd11, 1'b0, 8'd21);
    reset = 1'b1;
    q.delete();
    @(negedge clock);
    chk("t5_out_valid_in_reset", 32'(bus.out_valid), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("t5_out_valid_after_reset", 32'(bus.out_valid), 32'd0);
    @(posedge clock);
    #1;
    base = out_count;
    send(8'd20, 8'd30, 1'b0, 8'd50);
    send(8'd40, 8'd50, 1'b0, 8'd90);
    send(8'd60, 8'd70, 1'b0, 8'd130);
    send(8'd80, 8'd90, 1'b1, 8'd170);
    drain("t5", base, 4);

    // Randomised stream with random gaps, back-pressure and bursts
    base = out_count;
    done = 0;
    fork
      begin
        while (!done) begin
          @(posedge clock);
          #1;
          bus.out_ready = ($urandom_range(0, 2) != 0);
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clock);
            #1;
          end
          ra = 8'($urandom_range(0, 255));
          rb = 8'($urandom_range(0, 255));
          rl = ($urandom_range(0, 7) == 0);
          rs = ra + rb;
          send(ra, rb, rl, rs);
        end
        done = 1;
      end
    join
    bus.out_ready = 1'b1;
    drain("t6", base, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
